// File: rtl/pic_pkg.sv
// -----------------------------------------------------------------------------
// pic_pkg
// Shared types and constants for the 8259A-style acknowledge sequencer.
//   NUM_LEVELS     : number of interrupt levels (8, level index is 3 bits)
//   level_t        : 3-bit interrupt level index
//   pic_state_e    : acknowledge FSM states
//   SPURIOUS_LEVEL : level reported when the first INTA finds no winner
//   level_onehot() : level index to one-hot request vector
// -----------------------------------------------------------------------------
package pic_pkg;

   localparam int NUM_LEVELS = 8;

   typedef logic [2:0] level_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PEND  = 3'd1,
      ACK1  = 3'd2,
      WAIT2 = 3'd3,
      ACK2  = 3'd4
   } pic_state_e;

   localparam level_t SPURIOUS_LEVEL = 3'd7;

   // Reset priority pointer: IR7 lowest, so IR0 is highest.
   localparam level_t RESET_LOWEST_PTR = 3'd7;

   function automatic logic [NUM_LEVELS-1:0] level_onehot(input level_t lvl);
      logic [NUM_LEVELS-1:0] vec;
      vec      = '0;
      vec[lvl] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/pic_priority_rank.sv
// -----------------------------------------------------------------------------
// pic_priority_rank
// Combinational rotating-priority encoder.
// Ports:
//   req        in  8  request vector (one bit per level)
//   lowest_ptr in  3  level currently holding the lowest priority
//   valid      out 1  at least one request bit is set
//   level      out 3  highest-ranked set level (SPURIOUS_LEVEL when none)
// Rank order is lowest_ptr+1 (highest) ... lowest_ptr (lowest), modulo 8.
// -----------------------------------------------------------------------------
module pic_priority_rank
   import pic_pkg::*;
(
   input  logic [NUM_LEVELS-1:0] req,
   input  level_t                lowest_ptr,
   output logic                  valid,
   output level_t                level
);

   // Walk from the lowest-ranked slot up to the highest; the last hit wins,
   // so the highest-ranked set level ends up in 'level'.
   always_comb begin
      valid = 1'b0;
      level = SPURIOUS_LEVEL;
      for (int i = NUM_LEVELS; i >= 1; i--) begin
         if (req[lowest_ptr + level_t'(i)]) begin
            valid = 1'b1;
            level = lowest_ptr + level_t'(i);
         end
      end
   end

endmodule

// File: rtl/pic_ack_sequencer.sv
// -----------------------------------------------------------------------------
// pic_ack_sequencer
// Interrupt sequencing controller: raises INT, runs the two-pulse INTA cycle,
// drives the vector byte, owns the In-Service Register and applies EOIs with
// optional priority rotation.
// Optional feature macro: PIC_AEOI_EN (adds the aeoi port; automatic EOI at
// the end of the second INTA pulse).
// Ports:
//   clock        in  1  system clock, rising edge
//   reset        in  1  asynchronous active-low reset
//   irr          in  8  pending requests
//   imr          in  8  mask, 1 = masked
//   inta_n       in  1  CPU acknowledge, active low, synchronous
//   eoi_cmd      in  1  one-cycle EOI strobe
//   eoi_specific in  1  1 = specific EOI on eoi_level
//   eoi_level    in  3  level for specific EOI
//   rotate_en    in  1  rotate priority on EOI
//   vector_base  in  5  vector bits T7..T3
//   aeoi         in  1  automatic EOI mode (PIC_AEOI_EN only)
//   int_out      out 1  interrupt request to CPU
//   isr          out 8  In-Service Register
//   irr_clear    out 8  one-cycle clear pulse for the acknowledged IRR bit
//   data_out     out 8  vector byte
//   data_oe      out 1  vector drive enable
// -----------------------------------------------------------------------------
module pic_ack_sequencer
   import pic_pkg::*;
#(
   parameter int NUM_LEVELS = pic_pkg::NUM_LEVELS
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_LEVELS-1:0] irr,
   input  logic [NUM_LEVELS-1:0] imr,
   input  logic                  inta_n,
   input  logic                  eoi_cmd,
   input  logic                  eoi_specific,
   input  level_t                eoi_level,
   input  logic                  rotate_en,
   input  logic [4:0]            vector_base,
`ifdef PIC_AEOI_EN
   input  logic                  aeoi,
`endif
   output logic                  int_out,
   output logic [NUM_LEVELS-1:0] isr,
   output logic [NUM_LEVELS-1:0] irr_clear,
   output logic [7:0]            data_out,
   output logic                  data_oe
);

   pic_state_e state;
   level_t     lowest_ptr;
   level_t     ack_level;
   logic       inta_prev;
   logic       inta_fall;

   logic       isr_top_valid;
   level_t     isr_top;
   level_t     isr_top_pos;
   logic       win_valid;
   level_t     winner;

   logic [NUM_LEVELS-1:0] above_isr;
   logic [NUM_LEVELS-1:0] qual_req;
   logic [NUM_LEVELS-1:0] ack_set;
   logic [NUM_LEVELS-1:0] eoi_mask;
   logic [NUM_LEVELS-1:0] aeoi_mask;
   logic       eoi_hit;
   level_t     eoi_sel;
   logic       aeoi_hit;

   assign inta_fall = ~inta_n & inta_prev;

   // Highest in-service level bounds which requests may nest above it.
   pic_priority_rank u_isr_rank (
      .req        (isr),
      .lowest_ptr (lowest_ptr),
      .valid      (isr_top_valid),
      .level      (isr_top)
   );

   // Rank position 0 is the highest priority slot.
   assign isr_top_pos = isr_top - lowest_ptr - 3'd1;

   for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_above
      level_t pos;
      assign pos           = level_t'(gi) - lowest_ptr - 3'd1;
      assign above_isr[gi] = !isr_top_valid || (pos < isr_top_pos);
   end

   assign qual_req = irr & ~imr & above_isr;

   pic_priority_rank u_win_rank (
      .req        (qual_req),
      .lowest_ptr (lowest_ptr),
      .valid      (win_valid),
      .level      (winner)
   );

   // A spurious acknowledge (no winner at the first INTA edge) sets nothing.
   assign ack_set = (state == PEND && inta_fall && win_valid) ? level_onehot(winner) : '0;

   // EOI works on the pre-update ISR; a miss is a no-op and does not rotate.
   assign eoi_sel  = eoi_specific ? eoi_level : isr_top;
   assign eoi_hit  = eoi_cmd && (eoi_specific ? isr[eoi_level] : isr_top_valid);
   assign eoi_mask = eoi_hit ? level_onehot(eoi_sel) : '0;

`ifdef PIC_AEOI_EN
   logic ack_spurious;
   assign aeoi_hit = aeoi && (state == ACK2) && inta_n && !ack_spurious;
`else
   assign aeoi_hit = 1'b0;
`endif
   assign aeoi_mask = aeoi_hit ? level_onehot(ack_level) : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         lowest_ptr <= RESET_LOWEST_PTR;
         ack_level  <= '0;
         inta_prev  <= 1'b1;
         int_out    <= 1'b0;
         isr        <= '0;
         irr_clear  <= '0;
         data_out   <= '0;
         data_oe    <= 1'b0;
`ifdef PIC_AEOI_EN
         ack_spurious <= 1'b0;
`endif
      end else begin
         inta_prev <= inta_n;
         irr_clear <= '0;

         // Acknowledge set lands after the clears, so a coincident EOI
         // cannot remove the bit being acknowledged.
         isr <= (isr & ~eoi_mask & ~aeoi_mask) | ack_set;

         if (eoi_hit && rotate_en) begin
            lowest_ptr <= eoi_sel;
         end
         if (aeoi_hit && rotate_en) begin
            lowest_ptr <= ack_level;
         end

         case (state)
            IDLE: begin
               if (win_valid) begin
                  state   <= PEND;
                  int_out <= 1'b1;
               end
            end
            PEND: begin
               if (inta_fall) begin
                  state     <= ACK1;
                  int_out   <= 1'b0;
                  ack_level <= win_valid ? winner : SPURIOUS_LEVEL;
                  irr_clear <= ack_set;
`ifdef PIC_AEOI_EN
                  ack_spurious <= !win_valid;
`endif
               end else if (!win_valid) begin
                  state   <= IDLE;
                  int_out <= 1'b0;
               end
            end
            ACK1: begin
               if (inta_n) begin
                  state <= WAIT2;
               end
            end
            WAIT2: begin
               if (inta_fall) begin
                  state    <= ACK2;
                  data_out <= {vector_base, ack_level};
                  data_oe  <= 1'b1;
               end
            end
            ACK2: begin
               if (inta_n) begin
                  state   <= IDLE;
                  data_oe <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
